// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the MEM-stage load/store unit.
// Holds the FSM state enum, RV32I funct3 size codes and the bus byte-enable width.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int BE_WIDTH = 4;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store unit.
// Request side: we_i/f3_i/off_i/wdata_i -> be_o, lane_wdata_o, fault_o (misaligned or
// illegal funct3). Load side: ld_f3_i/ld_off_i/rdata_i -> ld_data_o (aligned, extended).
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  we_i,
    input  logic [2:0]            f3_i,
    input  logic [1:0]            off_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [BE_WIDTH-1:0]   be_o,
    output logic [DATA_WIDTH-1:0] lane_wdata_o,
    output logic                  fault_o,
    input  logic [2:0]            ld_f3_i,
    input  logic [1:0]            ld_off_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic [DATA_WIDTH-1:0] ld_data_o
);

    logic is_b;
    logic is_h;
    logic is_w;
    logic [DATA_WIDTH-1:0] sh;

    // Unsigned variants only exist for loads.
    assign is_b = (f3_i == F3_B) || (!we_i && f3_i == F3_BU);
    assign is_h = (f3_i == F3_H) || (!we_i && f3_i == F3_HU);
    assign is_w = (f3_i == F3_W);

    always_comb begin
        be_o         = '0;
        lane_wdata_o = '0;
        fault_o      = 1'b0;
        unique case (1'b1)
            is_b: begin
                be_o         = BE_WIDTH'(1) << off_i;
                lane_wdata_o = {4{wdata_i[7:0]}};
            end
            is_h: begin
                be_o         = off_i[1] ? 4'b1100 : 4'b0011;
                lane_wdata_o = {2{wdata_i[15:0]}};
                fault_o      = off_i[0];
            end
            is_w: begin
                be_o         = 4'b1111;
                lane_wdata_o = wdata_i;
                fault_o      = (off_i != 2'b00);
            end
            default: fault_o = 1'b1;
        endcase
        if (!we_i) lane_wdata_o = '0;
    end

    assign sh = rdata_i >> {ld_off_i, 3'b000};

    always_comb begin
        ld_data_o = rdata_i;
        unique case (ld_f3_i)
            F3_B:    ld_data_o = {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]};
            F3_H:    ld_data_o = {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
            F3_BU:   ld_data_o = {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
            F3_HU:   ld_data_o = {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
            default: ld_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem.sv
// lsu_mem: MEM-stage load/store responder driving a word-addressed req/gnt/rvalid bus.
// Ports: pipeline request in, stall_o/done_o/rdata_o/misalign_o/timeout_o out, bus_* side.
// Optional LSU_PERF_CNT_EN adds load_cnt_o, store_cnt_o, stall_cnt_o counters.
module lsu_mem
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    input  logic                  mem_wren_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  stall_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  misalign_o,
    output logic                  timeout_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [DATA_WIDTH-1:0] bus_addr_o,
    output logic [BE_WIDTH-1:0]   bus_be_o,
    output logic [DATA_WIDTH-1:0] bus_wdata_o,
    input  logic                  bus_gnt_i,
    input  logic                  bus_rvalid_i,
    input  logic [DATA_WIDTH-1:0] bus_rdata_i
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0]           load_cnt_o,
    output logic [31:0]           store_cnt_o,
    output logic [31:0]           stall_cnt_o
`endif
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    state_e                state;
    logic [CW-1:0]         cnt;
    logic [2:0]            f3_q;
    logic [1:0]            off_q;
    logic                  is_store_q;
    logic [BE_WIDTH-1:0]   be;
    logic [DATA_WIDTH-1:0] lane_wdata;
    logic                  fault;
    logic [DATA_WIDTH-1:0] ld_data;

    lsu_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_align (
        .we_i        (mem_wren_i),
        .f3_i        (funct3_i),
        .off_i       (addr_i[1:0]),
        .wdata_i     (wdata_i),
        .be_o        (be),
        .lane_wdata_o(lane_wdata),
        .fault_o     (fault),
        .ld_f3_i     (f3_q),
        .ld_off_i    (off_q),
        .rdata_i     (bus_rdata_i),
        .ld_data_o   (ld_data)
    );

    // The IDLE term must freeze the pipeline in the same cycle the request appears.
    assign stall_o = (state == REQ) || (state == WAIT) ||
                     (state == IDLE && req_valid_i && !rst_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            f3_q        <= '0;
            off_q       <= '0;
            is_store_q  <= 1'b0;
            done_o      <= 1'b0;
            rdata_o     <= '0;
            misalign_o  <= 1'b0;
            timeout_o   <= 1'b0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_be_o    <= '0;
            bus_wdata_o <= '0;
        end else begin
            done_o     <= 1'b0;
            rdata_o    <= '0;
            misalign_o <= 1'b0;
            timeout_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        f3_q       <= funct3_i;
                        off_q      <= addr_i[1:0];
                        is_store_q <= mem_wren_i;
                        if (fault) begin
                            state      <= DONE;
                            done_o     <= 1'b1;
                            misalign_o <= 1'b1;
                        end else begin
                            state       <= REQ;
                            bus_req_o   <= 1'b1;
                            bus_we_o    <= mem_wren_i;
                            bus_addr_o  <= {addr_i[DATA_WIDTH-1:2], 2'b00};
                            bus_be_o    <= be;
                            bus_wdata_o <= lane_wdata;
                        end
                    end
                end
                REQ: begin
                    if (bus_gnt_i) begin
                        bus_req_o <= 1'b0;
                        cnt       <= '0;
                        if (is_store_q) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus_rvalid_i) begin
                        state   <= DONE;
                        done_o  <= 1'b1;
                        rdata_o <= ld_data;
                    end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        state     <= DONE;
                        done_o    <= 1'b1;
                        timeout_o <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LSU_PERF_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            load_cnt_o  <= '0;
            store_cnt_o <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (stall_o) stall_cnt_o <= stall_cnt_o + 32'd1;
            if (done_o && !misalign_o && !timeout_o) begin
                if (is_store_q) store_cnt_o <= store_cnt_o + 32'd1;
                else            load_cnt_o  <= load_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lsu_mem.sv
// tb_lsu_mem: self-checking bench for lsu_mem.
// Directed vector table, random accesses against a reference model, reset corner cases.
module tb_lsu_mem;

    localparam int TO = 16;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        mem_wren_i = 1'b0;
    logic [2:0]  funct3_i = '0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        stall_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        misalign_o;
    logic        timeout_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i = 1'b0;
    logic        bus_rvalid_i = 1'b0;
    logic [31:0] bus_rdata_i = '0;

    lsu_mem #(
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .mem_wren_i  (mem_wren_i),
        .funct3_i    (funct3_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .stall_o     (stall_o),
        .done_o      (done_o),
        .rdata_o     (rdata_o),
        .misalign_o  (misalign_o),
        .timeout_o   (timeout_o),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_be_o    (bus_be_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_gnt_i   (bus_gnt_i),
        .bus_rvalid_i(bus_rvalid_i),
        .bus_rdata_i (bus_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] word;
        int          gdly;
        int          rdly;
    } vin_t;

    typedef struct packed {
        int          done_c;
        logic [31:0] rdata;
        logic        mis;
        logic        to;
        logic        req;
        logic [31:0] baddr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        we;
    } exp_t;

    typedef struct packed {
        int          done_c;
        int          stalls;
        logic        stall_done;
        logic [31:0] rdata;
        logic        mis;
        logic        to;
        logic        req;
        logic [31:0] baddr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        we;
    } obs_t;

    typedef struct packed {
        vin_t v;
        exp_t e;
    } rec_t;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic vin_t mkv(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] word, input int gdly, input int rdly);
        vin_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.word = word; v.gdly = gdly; v.rdly = rdly;
        return v;
    endfunction

    function automatic exp_t mke(input int done_c, input logic [31:0] rdata,
                                 input logic mis, input logic to, input logic req,
                                 input logic [31:0] baddr, input logic [3:0] be,
                                 input logic [31:0] wd, input logic we);
        exp_t e;
        e.done_c = done_c; e.rdata = rdata; e.mis = mis; e.to = to; e.req = req;
        e.baddr = baddr; e.be = be; e.wd = wd; e.we = we;
        return e;
    endfunction

    // Reference model: derived from RV32I lane rules with plain arithmetic.
    function automatic exp_t model(input vin_t v);
        exp_t        e;
        int          sz;
        int          off;
        bit          legal;
        bit          mis;
        logic [31:0] sh;
        logic [31:0] val;
        e = '0;
        sz = int'(v.f3[1:0]);
        off = int'(v.addr % 4);
        legal = (v.f3 == 3'd0 || v.f3 == 3'd1 || v.f3 == 3'd2) ||
                (!v.we && (v.f3 == 3'd4 || v.f3 == 3'd5));
        mis = (sz == 1 && (off % 2) != 0) || (sz == 2 && off != 0);
        if (!legal || mis) begin
            e.done_c = 1;
            e.mis = 1'b1;
            return e;
        end
        e.req = 1'b1;
        e.we = v.we;
        e.baddr = v.addr - 32'(off);
        case (sz)
            0:       e.be = 4'(1 << off);
            1:       e.be = (off >= 2) ? 4'hC : 4'h3;
            default: e.be = 4'hF;
        endcase
        if (v.we) begin
            case (sz)
                0:       e.wd = (v.wdata % 256) * 32'h0101_0101;
                1:       e.wd = (v.wdata % 65536) * 32'h0001_0001;
                default: e.wd = v.wdata;
            endcase
            e.done_c = v.gdly + 2;
            return e;
        end
        if (v.rdly < 0 || v.rdly >= TO) begin
            e.to = 1'b1;
            e.done_c = v.gdly + 2 + TO;
            return e;
        end
        sh = v.word >> (8 * off);
        case (sz)
            0: begin
                val = sh % 256;
                if (!v.f3[2] && val >= 128) val = val - 32'd256;
            end
            1: begin
                val = sh % 65536;
                if (!v.f3[2] && val >= 32768) val = val - 32'd65536;
            end
            default: val = sh;
        endcase
        e.rdata = val;
        e.done_c = v.gdly + 3 + v.rdly;
        return e;
    endfunction

    // Entered and left on a falling edge with the DUT in IDLE.
    task automatic run(input vin_t v, output obs_t o);
        int reqc;
        int waitc;
        bit granted;
        o = '0;
        o.done_c = -1;
        reqc = 0;
        waitc = 0;
        granted = 0;
        req_valid_i = 1'b1;
        mem_wren_i = v.we;
        funct3_i = v.f3;
        addr_i = v.addr;
        wdata_i = v.wdata;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (done_o) begin
                o.done_c = c;
                o.rdata = rdata_o;
                o.mis = misalign_o;
                o.to = timeout_o;
                o.stall_done = stall_o;
                break;
            end
            if (stall_o) o.stalls++;
            bus_gnt_i = 1'b0;
            bus_rvalid_i = 1'b0;
            bus_rdata_i = ~v.word;
            if (bus_req_o) begin
                o.req = 1'b1;
                o.baddr = bus_addr_o;
                o.be = bus_be_o;
                o.wd = bus_wdata_o;
                o.we = bus_we_o;
                if (reqc == v.gdly) begin
                    bus_gnt_i = 1'b1;
                    granted = 1;
                end
                reqc++;
            end else if (granted) begin
                if (waitc == v.rdly) begin
                    bus_rvalid_i = 1'b1;
                    bus_rdata_i = v.word;
                end
                waitc++;
            end
            @(negedge clk_i);
        end
        req_valid_i = 1'b0;
        bus_gnt_i = 1'b0;
        bus_rvalid_i = 1'b0;
        if (o.done_c < 0) begin
            rst_i = 1'b1;
            @(negedge clk_i);
            rst_i = 1'b0;
        end
        @(negedge clk_i);
    endtask

    task automatic compare(input string tag, input exp_t e, input obs_t o);
        chk({tag, ".done_cycle"}, 32'(o.done_c), 32'(e.done_c));
        chk({tag, ".stall_cycles"}, 32'(o.stalls), 32'(e.done_c));
        chk({tag, ".stall_at_done"}, 32'(o.stall_done), 32'd0);
        chk({tag, ".rdata"}, o.rdata, e.rdata);
        chk({tag, ".misalign"}, 32'(o.mis), 32'(e.mis));
        chk({tag, ".timeout"}, 32'(o.to), 32'(e.to));
        chk({tag, ".bus_req_seen"}, 32'(o.req), 32'(e.req));
        if (e.req) begin
            chk({tag, ".bus_addr"}, o.baddr, e.baddr);
            chk({tag, ".bus_be"}, 32'(o.be), 32'(e.be));
            chk({tag, ".bus_wdata"}, o.wd, e.wd);
            chk({tag, ".bus_we"}, 32'(o.we), 32'(e.we));
        end
    endtask

    initial begin
        rec_t tbl[$];
        obs_t o;
        vin_t v;

        // Directed vectors with hand-derived expectations.
        tbl.push_back({mkv(1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 2, 0),
                       mke(4, 0, 0, 0, 1, 32'h100, 4'hF, 32'hDEADBEEF, 1)});
        tbl.push_back({mkv(1, 3'd0, 32'h103, 32'h000000A5, 0, 0, 0),
                       mke(2, 0, 0, 0, 1, 32'h100, 4'h8, 32'hA5A5A5A5, 1)});
        tbl.push_back({mkv(0, 3'd0, 32'h102, 0, 32'h12803456, 0, 0),
                       mke(3, 32'hFFFFFF80, 0, 0, 1, 32'h100, 4'h4, 0, 0)});
        tbl.push_back({mkv(0, 3'd5, 32'h102, 0, 32'h12803456, 0, 0),
                       mke(3, 32'h00001280, 0, 0, 1, 32'h100, 4'hC, 0, 0)});
        tbl.push_back({mkv(0, 3'd2, 32'h101, 0, 0, 0, 0),
                       mke(1, 0, 1, 0, 0, 0, 0, 0, 0)});
        tbl.push_back({mkv(0, 3'd2, 32'h100, 0, 32'h11111111, 0, -1),
                       mke(18, 0, 0, 1, 1, 32'h100, 4'hF, 0, 0)});
        tbl.push_back({mkv(1, 3'd1, 32'h202, 32'h1234ABCD, 0, 1, 0),
                       mke(3, 0, 0, 0, 1, 32'h200, 4'hC, 32'hABCDABCD, 1)});
        tbl.push_back({mkv(1, 3'd4, 32'h0, 32'h55, 0, 0, 0),
                       mke(1, 0, 1, 0, 0, 0, 0, 0, 0)});
        tbl.push_back({mkv(0, 3'd1, 32'h300, 0, 32'h00008001, 0, 0),
                       mke(3, 32'hFFFF8001, 0, 0, 1, 32'h300, 4'h3, 0, 0)});
        tbl.push_back({mkv(0, 3'd2, 32'h104, 0, 32'hCAFEF00D, 0, 15),
                       mke(18, 32'hCAFEF00D, 0, 0, 1, 32'h104, 4'hF, 0, 0)});
        tbl.push_back({mkv(0, 3'd3, 32'h0, 0, 0, 0, 0),
                       mke(1, 0, 1, 0, 0, 0, 0, 0, 0)});
        tbl.push_back({mkv(0, 3'd4, 32'h401, 0, 32'h00009900, 1, 2),
                       mke(6, 32'h00000099, 0, 0, 1, 32'h400, 4'h2, 0, 0)});
        tbl.push_back({mkv(1, 3'd1, 32'h101, 32'h1234, 0, 0, 0),
                       mke(1, 0, 1, 0, 0, 0, 0, 0, 0)});
        tbl.push_back({mkv(0, 3'd2, 32'h108, 0, 32'h0BADF00D, 0, 16),
                       mke(18, 0, 0, 1, 1, 32'h108, 4'hF, 0, 0)});

        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        #1;
        chk("reset.stall", 32'(stall_o), 0);
        chk("reset.done", 32'(done_o), 0);
        chk("reset.rdata", rdata_o, 0);
        chk("reset.bus_req", 32'(bus_req_o), 0);
        chk("reset.bus_addr", bus_addr_o, 0);
        chk("reset.bus_be", 32'(bus_be_o), 0);
        chk("reset.flags", 32'({misalign_o, timeout_o, bus_we_o}), 0);
        chk("reset.bus_wdata", bus_wdata_o, 0);
        @(negedge clk_i);

        for (int i = 0; i < tbl.size(); i++) begin
            run(tbl[i].v, o);
            compare($sformatf("vec%0d", i), tbl[i].e, o);
        end

        for (int i = 0; i < 40; i++) begin
            v.we = 1'($urandom_range(0, 1));
            v.f3 = 3'($urandom_range(0, 7));
            v.addr = $urandom;
            v.wdata = $urandom;
            v.word = $urandom;
            v.gdly = $urandom_range(0, 3);
            v.rdly = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
            run(v, o);
            compare($sformatf("rnd%0d", i), model(v), o);
        end

        // Reset while a request is pending on the bus.
        req_valid_i = 1'b1;
        mem_wren_i = 1'b0;
        funct3_i = 3'd2;
        addr_i = 32'h500;
        @(negedge clk_i);
        #1;
        chk("rst_req.pre_req", 32'(bus_req_o), 1);
        rst_i = 1'b1;
        @(negedge clk_i);
        #1;
        chk("rst_req.bus_req", 32'(bus_req_o), 0);
        chk("rst_req.done", 32'(done_o), 0);
        chk("rst_req.stall", 32'(stall_o), 0);
        rst_i = 1'b0;
        req_valid_i = 1'b0;
        @(negedge clk_i);
        v = mkv(0, 3'd2, 32'h502, 0, 0, 0, 0);
        run(v, o);
        compare("rst_req.idle", model(v), o);

        // Reset during WAIT, then a stale rvalid must be ignored.
        req_valid_i = 1'b1;
        mem_wren_i = 1'b0;
        funct3_i = 3'd2;
        addr_i = 32'h600;
        @(negedge clk_i);
        #1;
        bus_gnt_i = 1'b1;
        @(negedge clk_i);
        #1;
        bus_gnt_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk_i);
        #1;
        rst_i = 1'b0;
        req_valid_i = 1'b0;
        bus_rvalid_i = 1'b1;
        bus_rdata_i = 32'hFFFFFFFF;
        @(negedge clk_i);
        #1;
        bus_rvalid_i = 1'b0;
        chk("late_rvalid.done", 32'(done_o), 0);
        chk("late_rvalid.rdata", rdata_o, 0);
        @(negedge clk_i);
        #1;
        chk("late_rvalid.done2", 32'(done_o), 0);
        chk("late_rvalid.stall", 32'(stall_o), 0);
        @(negedge clk_i);
        v = mkv(1, 3'd0, 32'h601, 32'h3C, 0, 1, 0);
        run(v, o);
        compare("late_rvalid.after", model(v), o);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_mem.md
Name: lsu_mem

Overview:
Load/store responder for the MEM stage of the pipelined core. It consumes the EX/MEM register outputs: the store strobe, the ALU result as address, rs2 as store data, and funct3 from the latched instruction. It drives a word-addressed data bus with a req/gnt/rvalid handshake and returns the aligned, sign- or zero-extended load data for the MEM/WB register. It stalls the pipeline while a bus access is outstanding.

Parameters:
DATA_WIDTH, 32, data and address width; only 32 is supported.
TIMEOUT_CYCLES, 16, maximum cycles to wait for bus_rvalid_i after a load grant before the load is abandoned.

Ports:
clk_i  input  1  clock; all logic is on the rising edge.
rst_i  input  1  synchronous, active-high reset.
req_valid_i  input  1  MEM stage holds a load or store.
mem_wren_i  input  1  1 = store, 0 = load.
funct3_i  input  3  access size and signedness, per RV32I encoding.
addr_i  input  DATA_WIDTH  byte address (ALU result).
wdata_i  input  DATA_WIDTH  store data (rs2).
stall_o  output  1  freeze the IF through MEM stages.
done_o  output  1  one-cycle pulse; the access has completed.
rdata_o  output  DATA_WIDTH  load result; valid while done_o is high, 0 otherwise.
misalign_o  output  1  pulse with done_o on a misaligned access or an illegal funct3.
timeout_o  output  1  pulse with done_o on a load timeout.
bus_req_o  output  1  bus request.
bus_we_o  output  1  bus write enable.
bus_addr_o  output  DATA_WIDTH  word address; bits [1:0] are always 0.
bus_be_o  output  4  byte enables.
bus_wdata_o  output  DATA_WIDTH  lane-aligned store data.
bus_gnt_i  input  1  request accepted.
bus_rvalid_i  input  1  read data valid.
bus_rdata_i  input  DATA_WIDTH  read data.

Behaviour:
- Reset: state goes to IDLE, the timeout counter clears, and every output is 0.
- Reset has priority over all other events. Reset mid-access drops bus_req_o on the same edge. A late bus_rvalid_i after reset is ignored.
- funct3 decode:
  - 000 is byte, 001 is half, 010 is word, 100 is byte unsigned, 101 is half unsigned.
  - 011, 110 and 111 are illegal.
  - For stores, only 000, 001 and 010 are legal.
- Misaligned conditions: a half access with addr[0]=1, or a word access with addr[1:0]≠0.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE, legal request: bus_addr_o, bus_we_o, bus_be_o and bus_wdata_o are registered from the inputs, and the next state is REQ. stall_o=1 combinationally in this cycle.
  - IDLE, misaligned or illegal request: the next state is DONE with the fault flag latched. No bus activity occurs. stall_o=1.
  - REQ: bus_req_o=1. The bus outputs are held stable until bus_gnt_i. On grant, a store goes to DONE and a load goes to WAIT.
  - WAIT: bus_req_o=0, and the counter increments every cycle. bus_rvalid_i is never expected in the grant cycle; it is ignored outside WAIT. On bus_rvalid_i, the extracted data is captured and the next state is DONE. When the counter reaches TIMEOUT_CYCLES-1 without rvalid, the next state is DONE with timeout latched and rdata 0.
  - DONE: done_o=1, stall_o=0, and the next state is IDLE unconditionally. The pipeline advances at the end of this cycle. The following IDLE cycle takes the next instruction, giving a minimum 3-cycle store and 4-cycle load.
- Store lanes:
  - Byte: bus_be_o = 1<<addr[1:0], with the byte replicated on all 4 lanes.
  - Half: bus_be_o = addr[1] ? 1100 : 0011, with the half replicated on both halves.
  - Word: bus_be_o = 1111.
- Loads: the same bus_be_o pattern is driven, and bus_wdata_o = 0.
- Load extract: the byte or half is selected by addr[1:0] and sign- or zero-extended to 32 bits per funct3.
- Fault completion: on a fault DONE, rdata_o = 0 and exactly one of misalign_o or timeout_o pulses.

Optional Feature:
LSU_PERF_CNT_EN
- Defined: adds the outputs load_cnt_o, store_cnt_o and stall_cnt_o, each 32 bits.
  - load_cnt_o and store_cnt_o increment on successful, non-fault done_o.
  - stall_cnt_o increments every cycle stall_o=1.
  - All three clear on rst_i and wrap modulo 2^32.
- Undefined: these ports and their logic are absent, and all other behaviour is identical.

Decomposition:
- lsu_pkg holds:
  - the state_e enum (IDLE, REQ, WAIT, DONE);
  - the funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the BE_WIDTH=4 constant.
- lsu_align is one combinational sub-module. It provides be generation, store lane replication, load extract/extend, and the misalign/illegal check; the FSM instantiates it.

Test Plan:
- SW, addr 0x100, data 0xDEADBEEF, gnt after 2 cycles:
  - bus_addr 0x100, be 1111, wdata 0xDEADBEEF;
  - stall for 4 cycles, then done with no fault.
- SB, addr 0x103, data 0x000000A5:
  - be 1000, wdata 0xA5A5A5A5, bus_addr 0x100.
- LB, addr 0x102, rdata 0x12 80 34 56 (byte 2 = 0x80), rvalid 1 cycle after gnt:
  - rdata_o 0xFFFFFF80 with done.
- LHU on the same word at addr 0x102:
  - rdata_o 0x00001280.
- LW, addr 0x101:
  - no bus_req_o;
  - done plus misalign_o on the 2nd cycle, rdata_o 0.
- LW granted, rvalid withheld:
  - timeout_o and done after TIMEOUT_CYCLES cycles in WAIT.
- Separately, assert rst_i while in REQ:
  - bus_req_o is 0 on the next cycle and the state is IDLE.
